// File: rtl/data_sram_resp.sv
// rtl/data_sram_resp.sv - data SRAM port with registered read, byte writes and timer/LED/switch MMIO
module data_sram_resp #(
  parameter int          ADDR_W     = 10,
  parameter logic [31:0] TIMER_INIT = 32'h0
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_wen,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  output logic [15:0] led,
  input  logic [7:0]  switch
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [31:0]       mem [DEPTH];
  logic              active;
  logic [31:0]       timer;
  logic [31:0]       timer_inc;
  logic [31:0]       timer_nxt;
  logic [15:0]       led_nxt;
  logic [31:0]       rd_val;
  logic              is_mmio;
  logic              sel_timer;
  logic              sel_led;
  logic              sel_switch;
  logic [ADDR_W-1:0] word_idx;
  logic              do_wr;
  logic              do_rd;
  logic              unused_addr_bits;

  assign is_mmio    = (data_sram_addr[31:16] == 16'hBFAF);
  assign sel_timer  = is_mmio && (data_sram_addr[15:0] == 16'hE000);
  assign sel_led    = is_mmio && (data_sram_addr[15:0] == 16'hF000);
  assign sel_switch = is_mmio && (data_sram_addr[15:0] == 16'hF004);
  assign word_idx   = data_sram_addr[ADDR_W+1:2];

  // Byte-offset bits and the aliased upper address bits are deliberately dropped.
  assign unused_addr_bits = ^data_sram_addr;

  // The first edge after reset release only arms the port; requests count from the next one.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) active <= 1'b0;
    else         active <= 1'b1;
  end

  assign do_wr = active && data_sram_en && (data_sram_wen != 4'b0000);
  assign do_rd = active && data_sram_en && (data_sram_wen == 4'b0000);

  // RAM contents survive reset, so this array has no reset branch.
  always_ff @(posedge clk) begin
    if (do_wr && !is_mmio) begin
      for (int i = 0; i < 4; i++) begin
        if (data_sram_wen[i]) mem[word_idx][8*i +: 8] <= data_sram_wdata[8*i +: 8];
      end
    end
  end

  always_comb begin
    timer_inc = timer + 32'd1;
    timer_nxt = timer_inc;
    if (do_wr && sel_timer) begin
      for (int i = 0; i < 4; i++) begin
        if (data_sram_wen[i]) timer_nxt[8*i +: 8] = data_sram_wdata[8*i +: 8];
      end
    end
  end

  always_comb begin
    led_nxt = led;
    if (do_wr && sel_led) begin
      if (data_sram_wen[0]) led_nxt[7:0]  = data_sram_wdata[7:0];
      if (data_sram_wen[1]) led_nxt[15:8] = data_sram_wdata[15:8];
    end
  end

  always_comb begin
    rd_val = 32'h0;
    if (!is_mmio)        rd_val = mem[word_idx];
    else if (sel_timer)  rd_val = timer;
    else if (sel_led)    rd_val = {16'h0, led};
    else if (sel_switch) rd_val = {24'h0, switch};
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      timer           <= TIMER_INIT;
      led             <= 16'h0;
      data_sram_rdata <= 32'h0;
    end else begin
      timer <= timer_nxt;
      led   <= led_nxt;
      if (do_rd) data_sram_rdata <= rd_val;
    end
  end

endmodule

// File: tb/tb_data_sram_resp.sv
// tb/tb_data_sram_resp.sv - directed self-checking bench for data_sram_resp
module tb_data_sram_resp;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        data_sram_en = 1'b0;
  logic [3:0]  data_sram_wen = 4'h0;
  logic [31:0] data_sram_addr = 32'h0;
  logic [31:0] data_sram_wdata = 32'h0;
  logic [31:0] data_sram_rdata;
  logic [15:0] led;
  logic [7:0]  switch = 8'h5A;

  int tests = 0;
  int fails = 0;

  localparam logic [31:0] TINIT = 32'h0000_0100;

  data_sram_resp #(.ADDR_W(10), .TIMER_INIT(TINIT)) dut (
    .clk             (clk),
    .resetn          (resetn),
    .data_sram_en    (data_sram_en),
    .data_sram_wen   (data_sram_wen),
    .data_sram_addr  (data_sram_addr),
    .data_sram_wdata (data_sram_wdata),
    .data_sram_rdata (data_sram_rdata),
    .led             (led),
    .switch          (switch)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] w);
    @(negedge clk);
    data_sram_en = 1'b1; data_sram_wen = w; data_sram_addr = a; data_sram_wdata = d;
    @(posedge clk); #1;
    data_sram_en = 1'b0; data_sram_wen = 4'h0;
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string tag);
    @(negedge clk);
    data_sram_en = 1'b1; data_sram_wen = 4'h0; data_sram_addr = a;
    @(posedge clk); #1;
    data_sram_en = 1'b0;
    chk(tag, data_sram_rdata, exp);
  endtask

  initial begin
    #1;
    chk("reset_rdata", data_sram_rdata, 32'h0);
    chk("reset_led", {16'h0, led}, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk); resetn = 1'b1;
    @(posedge clk); #1;

    wr(32'h0000_0010, 32'hDEADBEEF, 4'hF);
    rd(32'h0000_0010, 32'hDEADBEEF, "ram_full_word");
    rd(32'h0000_1010, 32'hDEADBEEF, "ram_alias_low");
    rd(32'h8000_0010, 32'hDEADBEEF, "ram_alias_high");

    wr(32'h0000_0020, 32'h11223344, 4'hF);
    wr(32'h0000_0020, 32'hAABBCCDD, 4'b0101);
    rd(32'h0000_0020, 32'h11BB33DD, "ram_byte_merge");

    wr(32'hBFAF_F000, 32'hFFFF_A5A5, 4'hF);
    chk("led_write", {16'h0, led}, 32'h0000_A5A5);
    rd(32'hBFAF_F000, 32'h0000_A5A5, "led_read");
    wr(32'hBFAF_F000, 32'h1234_00FF, 4'b1101);
    chk("led_partial", {16'h0, led}, 32'h0000_A5FF);
    rd(32'hBFAF_F000, 32'h0000_A5FF, "led_partial_read");

    wr(32'hBFAF_E000, 32'hFFFF_FFFE, 4'hF);
    rd(32'hBFAF_E000, 32'hFFFF_FFFE, "timer_written");
    rd(32'hBFAF_E000, 32'hFFFF_FFFF, "timer_inc");
    rd(32'hBFAF_E000, 32'h0000_0000, "timer_wrap");
    wr(32'hBFAF_E000, 32'hAABB_CC55, 4'b0001);
    rd(32'hBFAF_E000, 32'h0000_0055, "timer_partial");

    rd(32'hBFAF_F004, 32'h0000_005A, "switch_read");
    wr(32'hBFAF_F004, 32'hFFFF_FFFF, 4'hF);
    rd(32'hBFAF_F004, 32'h0000_005A, "switch_ro");
    switch = 8'hC3;
    rd(32'hBFAF_F004, 32'h0000_00C3, "switch_sample");
    wr(32'hBFAF_1234, 32'hFFFF_FFFF, 4'hF);
    rd(32'hBFAF_1234, 32'h0000_0000, "mmio_unmapped");

    rd(32'hBFAF_F000, 32'h0000_A5FF, "led_before_reset");
    wr(32'h0000_0040, 32'h12345678, 4'hF);
    @(posedge clk); #1;
    chk("rdata_hold", data_sram_rdata, 32'h0000_A5FF);

    @(negedge clk);
    data_sram_en = 1'b1; data_sram_wen = 4'h0; data_sram_addr = 32'h0000_0040;
    #2 resetn = 1'b0;
    #1;
    chk("async_rst_rdata", data_sram_rdata, 32'h0);
    chk("async_rst_led", {16'h0, led}, 32'h0);
    data_sram_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pending_read", data_sram_rdata, 32'h0);
    @(negedge clk);
    resetn = 1'b1;
    data_sram_en = 1'b1; data_sram_wen = 4'hF; data_sram_addr = 32'h0000_0040;
    data_sram_wdata = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    data_sram_en = 1'b0; data_sram_wen = 4'h0;
    chk("release_ignored", data_sram_rdata, 32'h0);
    rd(32'hBFAF_E000, TINIT + 32'd1, "timer_init");
    rd(32'h0000_0040, 32'h12345678, "ram_kept");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
